// File: rtl/tag_way_array_pkg.sv
// Shared types for the lc3b L1 tag store: tag/set/way index types and the
// flush sweep state encoding.
package tag_way_array_pkg;

  localparam int unsigned LC3B_TAG_W = 8;
  localparam int unsigned LC3B_SETS  = 16;
  localparam int unsigned LC3B_WAYS  = 2;

  typedef logic [LC3B_TAG_W-1:0]         lc3b_tag;
  typedef logic [$clog2(LC3B_SETS)-1:0]  lc3b_set;
  typedef logic [$clog2(LC3B_WAYS)-1:0]  way_idx_t;

  typedef enum logic {IDLE, SWEEP} flush_state_e;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tag_way_array_plru.sv
// Pseudo-LRU tree helper. Nodes are heap-ordered (root 0, children 2n+1 and
// 2n+2); a node bit of 0 steers the victim into the lower half, 1 the upper.
// Purely combinational: the per-set bits live in the tag array.
module plru_tree #(
  parameter int WAYS = 2,
  localparam int WW  = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] tree_i,
  input  logic [WW-1:0]   touch_way_i,
  output logic [WW-1:0]   victim_o,
  output logic [WAYS-2:0] tree_o
);

  int   node;
  int   tnode;
  logic b;

  // Walk from the root following node bits; each bit taken is one victim bit.
  always_comb begin
    victim_o = '0;
    node     = 0;
    b        = 1'b0;
    for (int d = 0; d < WW; d++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS-1; n++)
        if (n == node) b = tree_i[n];
      victim_o[WW-1-d] = b;
      node = 2*node + 1 + int'(b);
    end
  end

  // Touch: every node on the path to touch_way points to the other subtree.
  always_comb begin
    tree_o = tree_i;
    tnode  = 0;
    for (int d = 0; d < WW; d++) begin
      tnode = (1 << d) - 1 + (int'(touch_way_i) >> (WW - d));
      for (int n = 0; n < WAYS-1; n++)
        if (n == tnode) tree_o[n] = ~touch_way_i[WW-1-d];
    end
  end

endmodule

// File: rtl/tag_way_array.sv
// N-way, S-set tag store: tags, valid, dirty and a PLRU tree per set, with
// combinational hit detection and a one-set-per-cycle invalidate-all sweep.
module tag_way_array
  import tag_way_array_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int TAG_W = 8,
  localparam int WW   = idx_w(WAYS),
  localparam int SW   = idx_w(SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SW-1:0]         set,
  input  logic [TAG_W-1:0]      lookup_tag,
  output logic                  hit,
  output logic [WW-1:0]         hit_way,
  output logic [WAYS*TAG_W-1:0] tag_out,
  output logic [WAYS-1:0]       valid_out,
  output logic [WAYS-1:0]       dirty_out,
  output logic [WW-1:0]         lru_way,
  input  logic                  access,
  input  logic                  load,
  input  logic [WW-1:0]         load_way,
  input  logic [TAG_W-1:0]      load_tag,
  input  logic                  load_dirty,
  input  logic                  mark_dirty,
  input  logic                  flush_req,
  output logic                  flush_busy
);

  logic [WAYS-1:0][TAG_W-1:0] tag_q   [SETS];
  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-1:0]            dirty_q [SETS];
  logic [WAYS-2:0]            plru_q  [SETS];

  flush_state_e    state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            idle;
  logic [WW-1:0]   touch_way;
  logic            touch_en;
  logic [WAYS-2:0] plru_touched;

  assign idle       = (state_q == IDLE);
  assign flush_busy = ~idle;
  assign tag_out    = tag_q[set];
  assign valid_out  = valid_q[set];
  assign dirty_out  = dirty_q[set];

  // A fill owns the PLRU update; an access only touches when it hits.
  assign touch_way = load ? load_way : hit_way;
  assign touch_en  = idle & (load | (access & hit));

  plru_tree #(.WAYS(WAYS)) u_plru (
    .tree_i      (plru_q[set]),
    .touch_way_i (touch_way),
    .victim_o    (lru_way),
    .tree_o      (plru_touched)
  );

  // Hit detect; descending scan so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (valid_q[set][w] && tag_q[set][w] == lookup_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    if (!idle) begin
      hit     = 1'b0;
      hit_way = '0;
    end
  end

  // Sweep FSM next state: one set cleared per cycle, SETS cycles total.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (flush_req) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(SETS-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tag/valid/dirty/PLRU store. mark_dirty is applied after the fill so a
  // same-way fill with load_dirty=0 still ends up dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        tag_q[s]   <= '0;
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (!idle) begin
      valid_q[cnt_q] <= '0;
      dirty_q[cnt_q] <= '0;
      plru_q[cnt_q]  <= '0;
    end else begin
      if (load) begin
        tag_q[set][load_way]   <= load_tag;
        valid_q[set][load_way] <= 1'b1;
        dirty_q[set][load_way] <= load_dirty;
      end
      if (mark_dirty && hit) dirty_q[set][hit_way] <= 1'b1;
      if (touch_en)          plru_q[set]           <= plru_touched;
    end
  end

endmodule

// File: tb/tb_tag_way_array.sv
// Bench for tag_way_array: a 2-way and a 4-way instance share one stimulus
// stream; both are compared every cycle against a per-set array model whose
// PLRU is a leaf-to-root heap walk.
module tb_tag_way_array;

  localparam int SETS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] set = '0;
  logic [7:0] lookup_tag = '0, load_tag = '0;
  logic [1:0] lw = '0;
  logic       access = 1'b0, load = 1'b0, load_dirty = 1'b0;
  logic       mark_dirty = 1'b0, flush_req = 1'b0;

  logic        h2, fb2;  logic [0:0] hw2, lru2; logic [15:0] to2; logic [1:0] v2, dy2;
  logic        h4, fb4;  logic [1:0] hw4, lru4; logic [31:0] to4; logic [3:0] v4, dy4;

  always #5 clk = ~clk;

  tag_way_array #(.WAYS(2), .SETS(SETS), .TAG_W(8)) d2 (
    .clk(clk), .rst(rst), .set(set), .lookup_tag(lookup_tag), .hit(h2), .hit_way(hw2),
    .tag_out(to2), .valid_out(v2), .dirty_out(dy2), .lru_way(lru2), .access(access),
    .load(load), .load_way(lw[0:0]), .load_tag(load_tag), .load_dirty(load_dirty),
    .mark_dirty(mark_dirty), .flush_req(flush_req), .flush_busy(fb2));

  tag_way_array #(.WAYS(4), .SETS(SETS), .TAG_W(8)) d4 (
    .clk(clk), .rst(rst), .set(set), .lookup_tag(lookup_tag), .hit(h4), .hit_way(hw4),
    .tag_out(to4), .valid_out(v4), .dirty_out(dy4), .lru_way(lru4), .access(access),
    .load(load), .load_way(lw), .load_tag(load_tag), .load_dirty(load_dirty),
    .mark_dirty(mark_dirty), .flush_req(flush_req), .flush_busy(fb4));

  // model: index 0 = 2-way instance, 1 = 4-way instance
  logic [7:0] m_tag [2][SETS][4];
  bit         m_val [2][SETS][4];
  bit         m_dty [2][SETS][4];
  bit         m_tr  [2][SETS][3];
  bit         m_busy;
  int         m_cnt;
  int tests = 0, fails = 0;

  function automatic int nways(int k); return k ? 4 : 2; endfunction

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < 4; w++) begin
          m_tag[k][s][w] = '0; m_val[k][s][w] = 0; m_dty[k][s][w] = 0;
        end
        for (int n = 0; n < 3; n++) m_tr[k][s][n] = 0;
      end
    m_busy = 0; m_cnt = 0;
  endtask

  task automatic m_hit(input int k, input int s, input logic [7:0] t, output bit h, output int hw);
    h = 0; hw = 0;
    if (!m_busy)
      for (int w = nways(k)-1; w >= 0; w--)
        if (m_val[k][s][w] && m_tag[k][s][w] == t) begin h = 1; hw = w; end
  endtask

  // victim: descend the heap, then leaf index minus internal-node count
  function automatic int m_victim(int k, int s);
    int i = 0;
    while (i < nways(k)-1) i = 2*i + 1 + int'(m_tr[k][s][i]);
    return i - (nways(k)-1);
  endfunction

  // touch: climb from the leaf, pointing each parent at the sibling side
  task automatic m_touch(input int k, input int s, input int w);
    int leaf = w + nways(k) - 1;
    while (leaf > 0) begin
      int p = (leaf - 1) / 2;
      m_tr[k][s][p] = (leaf == 2*p + 1);
      leaf = p;
    end
  endtask

  task automatic m_update();
    if (m_busy) begin
      for (int k = 0; k < 2; k++) begin
        for (int w = 0; w < 4; w++) begin m_val[k][m_cnt][w] = 0; m_dty[k][m_cnt][w] = 0; end
        for (int n = 0; n < 3; n++) m_tr[k][m_cnt][n] = 0;
      end
      m_cnt++;
      if (m_cnt == SETS) begin m_busy = 0; m_cnt = 0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit h; int hw; int wk;
        wk = k ? int'(lw) : int'(lw[0]);
        m_hit(k, set, lookup_tag, h, hw);
        if (load) begin
          m_tag[k][set][wk] = load_tag; m_val[k][set][wk] = 1; m_dty[k][set][wk] = load_dirty;
          m_touch(k, set, wk);
        end else if (access && h) m_touch(k, set, hw);
        if (mark_dirty && h) m_dty[k][set][hw] = 1;
      end
      if (flush_req) begin m_busy = 1; m_cnt = 0; end
    end
  endtask

  task automatic check();
    for (int k = 0; k < 2; k++) begin
      bit h; int hw;
      logic [31:0] et, ev, ed;
      et = 0; ev = 0; ed = 0;
      m_hit(k, set, lookup_tag, h, hw);
      for (int w = 0; w < nways(k); w++) begin
        et[w*8 +: 8] = m_tag[k][set][w];
        ev[w] = m_val[k][set][w];
        ed[w] = m_dty[k][set][w];
      end
      if (k == 0) begin
        chk("w2_hit", 32'(h2), 32'(h));       chk("w2_hit_way", 32'(hw2), hw);
        chk("w2_tag", 32'(to2), et);          chk("w2_valid", 32'(v2), ev);
        chk("w2_dirty", 32'(dy2), ed);        chk("w2_lru", 32'(lru2), m_victim(0, set));
        chk("w2_busy", 32'(fb2), 32'(m_busy));
      end else begin
        chk("w4_hit", 32'(h4), 32'(h));       chk("w4_hit_way", 32'(hw4), hw);
        chk("w4_tag", to4, et);               chk("w4_valid", 32'(v4), ev);
        chk("w4_dirty", 32'(dy4), ed);        chk("w4_lru", 32'(lru4), m_victim(1, set));
        chk("w4_busy", 32'(fb4), 32'(m_busy));
      end
    end
  endtask

  task automatic idle_in();
    access = 0; load = 0; mark_dirty = 0; flush_req = 0; load_dirty = 0;
  endtask

  // inputs are driven at the negedge; compare, take the posedge, update model
  task automatic step();
    #1 check();
    @(posedge clk);
    m_update();
    @(negedge clk);
    idle_in();
  endtask

  task automatic do_reset();
    rst = 1; idle_in();
    m_reset();
    #1 check();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic fill(input int s, input int w, input logic [7:0] t);
    set = 4'(s); lw = 2'(w); load_tag = t; load = 1; step();
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();

    // 1: empty set after reset
    set = 4'd5; lookup_tag = 8'h3C; #1;
    chk("t1_hit", 32'(h2), 0); chk("t1_valid", 32'(v2), 0); chk("t1_lru", 32'(lru2), 0);
    step();

    // 2: fill way0 then hit
    fill(5, 0, 8'h3C);
    set = 4'd5; lookup_tag = 8'h3C; #1;
    chk("t2_hit", 32'(h2), 1); chk("t2_hit_way", 32'(hw2), 0); chk("t2_lru", 32'(lru2), 1);
    step();

    // 3: 4-way fill 1..4, access tag 1, then fill the victim
    for (int w = 0; w < 4; w++) fill(3, w, 8'(w + 1));
    set = 4'd3; lookup_tag = 8'd1; access = 1; step();
    #1 chk("t3_lru", 32'(lru4), 2);
    fill(3, m_victim(1, 3), 8'd5);
    #1 chk("t3_valid", 32'(v4), 32'hF);

    // 4: mark_dirty on hit way1 together with a clean fill of way1
    set = 4'd3; lookup_tag = 8'd2; lw = 2'd1; load_tag = 8'd2; load = 1; load_dirty = 0;
    mark_dirty = 1; step();
    #1 chk("t4_dirty1", 32'(dy4[1]), 1);

    // 5: full sweep, mid-sweep load ignored, hit forced low
    set = 4'd3; lookup_tag = 8'd1; flush_req = 1; step();
    begin
      int bc = 0;
      for (int i = 0; i < 20; i++) begin
        set = 4'd3; lookup_tag = 8'd1;
        if (i == 8) begin set = 4'd7; lw = 2'd0; load_tag = 8'hAA; load = 1; end
        #1 if (fb4) bc++;
        if (i < 16) chk("t5_hit_low", 32'(h4), 0);
        step();
      end
      chk("t5_busy_cycles", bc, 16);
    end
    for (int s = 0; s < SETS; s++) begin
      set = 4'(s); #1 chk("t5_valid_clear", 32'(v4), 0); step();
    end

    // 6: reset at sweep cycle 7, then a fresh sweep starts at set 0
    fill(0, 0, 8'd9);
    fill(2, 1, 8'd9);
    flush_req = 1; step();
    for (int i = 0; i < 7; i++) step();
    do_reset();
    set = 4'd2; #1;
    chk("t6_busy", 32'(fb4), 0); chk("t6_valid", 32'(v4), 0);
    chk("t6_dirty", 32'(dy4), 0); chk("t6_lru", 32'(lru4), 0);
    fill(0, 0, 8'd9);
    fill(1, 0, 8'd9);
    flush_req = 1; step();
    step();
    set = 4'd0; #1 chk("t6_set0_cleared", 32'(v4), 0);
    set = 4'd1; #1 chk("t6_set1_kept", 32'(v4), 1);
    for (int i = 0; i < 16; i++) step();

    // random traffic with occasional flushes and one extra reset
    for (int i = 0; i < 500; i++) begin
      int s;
      s = int'($urandom_range(0, SETS-1));
      set = 4'(s);
      lookup_tag = ($urandom % 3 != 0) ? m_tag[1][s][$urandom % 4] : 8'($urandom % 16);
      access = 1'($urandom); mark_dirty = ($urandom % 4 == 0);
      load = ($urandom % 3 == 0); lw = 2'($urandom); load_tag = 8'($urandom % 16);
      load_dirty = 1'($urandom); flush_req = ($urandom % 40 == 0);
      for (int k = 0; k < 2; k++) begin
        int wk = k ? int'(lw) : int'(lw[0]);
        for (int w = 0; w < nways(k); w++)
          if (w != wk && m_val[k][s][w] && m_tag[k][s][w] == load_tag) load = 0;
      end
      if (i == 250) do_reset(); else step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
